// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO and its burst reader.
package fifo_pkg;

    localparam int FIFO_WIDTH  = 32;
    localparam int FIFO_DEPTH  = 1000;
    localparam int BURST_CNT_W = 10;   // 1023-word max burst covers FIFO_DEPTH

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/out_reg_slice.sv
// Valid/ready holding register: load captures a word, accept retires it,
// flush discards it and dominates both.
module out_reg_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             flush,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master: pops burst_len words from a first-word-fall-through FIFO
// and streams them out through a registered valid/ready slice.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = BURST_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             abort,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_shift_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] words_read
);

    rd_state_t        state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             pop, flush, done_nxt, aborted_nxt, take_start;

    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        flush       = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        take_start  = 1'b0;
        case (state)
            IDLE: begin
                // abort is meaningless here, so a coincident start still wins
                if (start) begin
                    take_start = 1'b1;
                    if (burst_len != '0) state_nxt = RUN;
                    else                 done_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    flush       = 1'b1;
                    aborted_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    pop = !fifo_empty && (remaining != '0) && (!out_valid || out_ready);
                    if (pop && remaining == CNT_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush       = 1'b1;
                    aborted_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (!out_valid || out_ready) begin
                    // last word leaves the slice on the same edge done rises
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            remaining  <= '0;
            words_read <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= done_nxt;
            aborted <= aborted_nxt;
            if (take_start) begin
                remaining  <= burst_len;
                words_read <= '0;
            end else if (pop) begin
                remaining  <= remaining - CNT_W'(1);
                words_read <= words_read + CNT_W'(1);
            end
        end
    end

    out_reg_slice #(.WIDTH(WIDTH)) u_out (
        .clk       (clk),
        .res       (res),
        .load      (pop),
        .load_data (fifo_data),
        .ready     (out_ready),
        .flush     (flush),
        .data      (out_data),
        .valid     (out_valid)
    );

    assign fifo_shift_out = pop;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model feeds the DUT, a
// scoreboard of expected words is checked at every accepted output.
module tb_fifo_burst_reader;

    localparam int W  = 32;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          res, start, abort, fifo_empty, out_ready;
    logic [CW-1:0] burst_len;
    logic [W-1:0]  fifo_data;
    logic          fifo_shift_out, out_valid, busy, done, aborted;
    logic [W-1:0]  out_data;
    logic [CW-1:0] words_read;

    fifo_burst_reader #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .res(res), .start(start), .burst_len(burst_len), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_shift_out(fifo_shift_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .aborted(aborted), .words_read(words_read)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int pop_cnt = 0, acc_cnt = 0, done_cnt = 0, ab_cnt = 0;
    bit busy_seen = 0, pop_now = 0;
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic void upd_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fq[0];
    endfunction

    task automatic push(input logic [W-1:0] d, input bit expect_out);
        fq.push_back(d);
        if (expect_out) exp_q.push_back(d);
        upd_fifo();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_now && fq.size() > 0) fq.delete(0);
        upd_fifo();
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        burst_len = CW'(len);
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done) begin
                n = i + 1;
                break;
            end
        end
    endtask

    // Monitor on the falling edge: inputs only move just after the rising edge.
    always @(negedge clk) begin
        pop_now = fifo_shift_out;
        if (fifo_shift_out) begin
            pop_cnt++;
            chk("pop_nonempty", 64'(fifo_empty), 64'd0);
        end
        if (done) begin
            done_cnt++;
            chk("done_without_valid", 64'(out_valid), 64'd0);
        end
        if (aborted) ab_cnt++;
        if (busy) busy_seen = 1;
        if (!res && out_valid && out_ready && !abort) begin
            acc_cnt++;
            if (exp_q.size() == 0) chk("extra_word", 64'(exp_q.size()), 64'd1);
            else                   chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        res = 1'b1; start = 1'b0; burst_len = '0; abort = 1'b0; out_ready = 1'b0;
        upd_fifo();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   64'(out_valid),      64'd0);
        chk("rst_busy",    64'(busy),           64'd0);
        chk("rst_done",    64'(done),           64'd0);
        chk("rst_aborted", 64'(aborted),        64'd0);
        chk("rst_wr",      64'(words_read),     64'd0);
        chk("rst_shift",   64'(fifo_shift_out), 64'd0);
        chk("rst_data",    64'(out_data),       64'd0);
        res = 1'b0;
        tick();

        // 1: four-word burst at full rate
        for (int i = 1; i <= 4; i++) push(W'(32'h11 * i), 1'b1);
        pop_cnt = 0; acc_cnt = 0; out_ready = 1'b1;
        do_start(4);
        wait_done(20, n);
        chk("t1_done_latency", 64'(n), 64'd5);
        chk("t1_wr",   64'(words_read), 64'd4);
        chk("t1_pops", 64'(pop_cnt),    64'd4);
        chk("t1_acc",  64'(acc_cnt),    64'd4);
        chk("t1_busy", 64'(busy),       64'd0);
        tick();
        chk("t1_done_1cyc", 64'(done), 64'd0);

        // 2: backpressure for three cycles after the first word
        for (int i = 1; i <= 5; i++) push(W'(32'hA0 + i), i <= 3);
        pop_cnt = 0;
        do_start(3);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t2_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_data", 64'(out_data), 64'hA1);
            chk("t2_stall_pop",  64'(fifo_shift_out), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_done(20, n);
        chk("t2_done",  64'(n > 0),      64'd1);
        chk("t2_pops",  64'(pop_cnt),    64'd3);
        chk("t2_left",  64'(fq.size()),  64'd2);
        chk("t2_wr",    64'(words_read), 64'd3);
        fq.delete(); upd_fifo();

        // 3: starved FIFO, words trickle in
        pop_cnt = 0;
        do_start(2);
        repeat (5) tick();
        chk("t3_no_pop_empty", 64'(pop_cnt), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        push(32'hB1, 1'b1);
        repeat (3) tick();
        push(32'hB2, 1'b1);
        wait_done(20, n);
        chk("t3_done", 64'(n > 0),      64'd1);
        chk("t3_pops", 64'(pop_cnt),    64'd2);
        chk("t3_wr",   64'(words_read), 64'd2);
        tick();

        // 4: zero-length burst
        pop_cnt = 0; done_cnt = 0; busy_seen = 0;
        do_start(0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        tick();
        chk("t4_done_1cyc", 64'(done),      64'd0);
        chk("t4_busy_seen", 64'(busy_seen), 64'd0);
        chk("t4_pops",      64'(pop_cnt),   64'd0);
        chk("t4_done_cnt",  64'(done_cnt),  64'd1);

        // 5: abort with the fourth word held, then a normal one-word burst
        for (int i = 0; i < 10; i++) push(W'(32'hC0 + i), i < 3);
        pop_cnt = 0; acc_cnt = 0; ab_cnt = 0; done_cnt = 0;
        do_start(10);
        for (int i = 0; i < 20 && acc_cnt != 3; i++) tick();
        chk("t5_acc",   64'(acc_cnt),    64'd3);
        chk("t5_wr",    64'(words_read), 64'd4);
        chk("t5_held",  64'(out_valid),  64'd1);
        chk("t5_hdata", 64'(out_data),   64'hC3);
        abort = 1'b1;
        #1;
        chk("t5_abort_nopop", 64'(fifo_shift_out), 64'd0);
        tick();
        abort = 1'b0;
        chk("t5_valid_drop", 64'(out_valid),  64'd0);
        chk("t5_aborted",    64'(aborted),    64'd1);
        chk("t5_busy",       64'(busy),       64'd0);
        chk("t5_wr_kept",    64'(words_read), 64'd4);
        tick();
        chk("t5_aborted_1cyc", 64'(aborted),   64'd0);
        chk("t5_no_done",      64'(done_cnt),  64'd0);
        chk("t5_ab_cnt",       64'(ab_cnt),    64'd1);
        chk("t5_left",         64'(fq.size()), 64'd6);
        exp_q.push_back(32'hC4);
        do_start(1);
        wait_done(20, n);
        chk("t5_restart_done", 64'(n > 0),      64'd1);
        chk("t5_restart_wr",   64'(words_read), 64'd1);
        chk("t5_restart_left", 64'(fq.size()),  64'd5);
        fq.delete(); upd_fifo();
        tick();

        // 6: reset mid-burst
        for (int i = 0; i < 5; i++) push(W'(32'hD0 + i), i == 0);
        done_cnt = 0; ab_cnt = 0;
        do_start(5);
        tick();
        tick();
        chk("t6_pre_wr",    64'(words_read), 64'd2);
        chk("t6_pre_valid", 64'(out_valid),  64'd1);
        out_ready = 1'b0;
        res = 1'b1;
        #1;
        chk("t6_valid", 64'(out_valid),      64'd0);
        chk("t6_busy",  64'(busy),           64'd0);
        chk("t6_wr",    64'(words_read),     64'd0);
        chk("t6_shift", 64'(fifo_shift_out), 64'd0);
        repeat (2) tick();
        res = 1'b0;
        repeat (3) tick();
        chk("t6_no_done",    64'(done_cnt), 64'd0);
        chk("t6_no_aborted", 64'(ab_cnt),   64'd0);
        chk("t6_idle",       64'(busy),     64'd0);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for the synchronous FIFO. It drains exactly burst_len words from the FIFO's shift_out/empty/data_out port and presents them on a registered valid/ready output stream to downstream logic, for example the regular-expression checker datapath. It takes over the pop-side role that the random testbench drives by hand, and it reports completion, words transferred and abort.

Parameters:
WIDTH, 32, data word width; matches the FIFO's WIDTH.
CNT_W, 10, burst-length/counter width; max burst 2^CNT_W-1 (1023, covers FIFO DEPTH 1000).

Ports:
clk  input  1  clock, rising edge
res  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
burst_len  input  CNT_W  words to read; sampled with start
abort  input  1  terminate current burst
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO head word (first-word-fall-through; valid when !fifo_empty)
fifo_shift_out  output  1  pop request to FIFO (combinational)
out_data  output  WIDTH  registered output word
out_valid  output  1  out_data holds a word
out_ready  input  1  downstream accepts word when out_valid & out_ready
busy  output  1  high in RUN or DRAIN
done  output  1  one-cycle pulse when a burst completes normally
aborted  output  1  one-cycle pulse when a burst ends by abort
words_read  output  CNT_W  words popped in current/last burst

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; out_data=0; busy=0; done=0; aborted=0; words_read=0; remaining=0; fifo_shift_out=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with burst_len!=0: remaining<=burst_len, words_read<=0, next state RUN.
  - start=1 with burst_len==0: done=1 next cycle, stay IDLE, no pop.
- RUN, pop condition: pop = !fifo_empty & remaining!=0 & (!out_valid | out_ready) & !abort.
  - fifo_shift_out = pop, combinational.
  - On pop: out_data<=fifo_data; out_valid<=1; remaining<=remaining-1; words_read<=words_read+1.
  - On accept without pop: out_valid<=0.
  - Latency: 1 cycle from the popping edge to out_valid. Throughput: 1 word/cycle while FIFO non-empty and out_ready=1.
  - fifo_empty=1: no pop; the held word stays stable.
  - out_ready=0 with out_valid=1: no pop (backpressure); out_data/out_valid stable.
  - When the last word pops (remaining 1->0): next state DRAIN.
- DRAIN: wait until out_valid=0 or out_valid&out_ready. Then out_valid<=0, done pulses for 1 cycle, state IDLE. done is never asserted while out_valid=1.
- abort (RUN or DRAIN):
  - No pop that cycle.
  - out_valid<=0; the held word is discarded, even if out_ready=1 the same cycle (abort wins).
  - aborted pulses next cycle; state IDLE; words_read retained.
  - abort in IDLE: ignored.
- start while busy: ignored. Simultaneous start and abort in IDLE: start taken.
- Counter widths: remaining and words_read are CNT_W unsigned; they cannot wrap because pops stop at remaining==0.
- busy = (state!=IDLE).
- Reset asserted mid-burst: immediate return to IDLE, out_valid drops asynchronously, no done/aborted pulse.

Decomposition:
- Shared package fifo_pkg: WIDTH/DEPTH defaults, CNT_W, state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
- One natural sub-module: out_reg_slice (WIDTH-wide valid/ready holding register with load/accept/flush).
- Counters and the FSM stay in the top module.

Test Plan:
- Reset then start, burst_len=4; FIFO preloaded 0x11,0x22,0x33,0x44; out_ready=1 -> four pops on consecutive cycles, out_data 0x11..0x44 on consecutive cycles, done 1 cycle after last accept, words_read=4.
- burst_len=3, FIFO holds 5 words; out_ready low 3 cycles after first word -> out_data stable at first word, no fifo_shift_out while stalled; exactly 3 pops, 2 words remain in FIFO.
- burst_len=2, FIFO empty 5 cycles then one word pushed per 3 cycles -> fifo_shift_out only when !fifo_empty; done after second accept; no pop while empty.
- burst_len=0 -> done pulse next cycle, busy never high, fifo_shift_out never high.
- burst_len=10, abort after 3 accepts with a 4th word held -> out_valid drops, aborted pulses, words_read=4, no done; subsequent start burst_len=1 works normally.
- res asserted mid-burst (words_read=2, out_valid=1) -> out_valid=0, busy=0, words_read=0 immediately; no pop, done or aborted.
